time_register_controller: RTL and testbench
===========================================

// Module: time_register_controller
// PURPOSE
//   Sequences writes into the alarm clock's two 13-bit BCD time registers:
//   the current-time register and the alarm register. It decides which
//   register is written, and with what value.
//   - RUN mode: the minute tick advances the current time.
//   - SET modes: user button pulses edit the hour and minute fields.
//   The register write port is shared. At most one write is issued per cycle.
// PARAMETERS
//   TIMEOUT_CYCLES  0    idle cycles in a SET state before an automatic return to RUN; 0 disables
//   TO_W            24   width of the timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//   Clock        in   1   system clock; rising edge
//   Clear        in   1   synchronous, active-high reset
//   mode_btn     in   1   1-cycle pulse, debounced upstream; advances the mode
//   inc_btn      in   1   1-cycle pulse, debounced upstream; increments the selected field
//   minute_tick  in   1   1-cycle pulse from the prescaler, once per minute
//   time_q       in   13  Q of the current-time register
//   alarm_q      in   13  Q of the alarm register
//   D_out        out  13  shared D bus to both registers
//   time_en      out  1   Enable of the current-time register
//   alarm_en     out  1   Enable of the alarm register
//   mode         out  3   current state encoding (drives display select)
//   pending      out  1   a minute tick is latched but not yet applied
// BEHAVIOUR
//   Field layout (BCD), identical for time and alarm:
//     [12:11] hour tens 0-2, [10:7] hour units, [6:4] minute tens 0-5, [3:0] minute units.
//   States: RUN=0, SET_T_HR=1, SET_T_MIN=2, SET_A_HR=3, SET_A_MIN=4; codes 5-7 go to RUN.
//   mode_btn transitions: RUN->1->2->3->4->RUN, taken at the next edge.
//   All outputs are registered. Clear: state RUN, D_out=0, time_en=0, alarm_en=0,
//     pending=0, timeout counter=0. Clear overrides every other input in that cycle.
//   Write protocol:
//     - The request is seen at edge N. D_out and *_en are high for exactly one cycle after N.
//     - The target register captures at edge N+1; the new Q is visible after N+1.
//     - "In flight" = time_en or alarm_en is high. While in flight, no new write is issued.
//     - inc_btn arriving while in flight is dropped.
//   time_en and alarm_en are never high together.
//   Minute tick handling:
//     - minute_tick sets pending. pending persists through an in-flight write.
//     - In RUN, if pending and not in flight: write time_q + 1 minute; pending clears
//       at the same edge that raises time_en.
//     - A tick arriving in the same cycle that pending is consumed re-sets pending;
//       no tick is lost.
//     - In any SET state, ticks are discarded and pending is forced to 0 (time is frozen).
//   Increment rules (inc_btn in a SET state, not in flight):
//     SET_T_HR / SET_A_HR   : hours+1, minutes unchanged; 23 -> 00.
//     SET_T_MIN / SET_A_MIN : minutes+1, hours unchanged; 59 -> 00, no carry into hours.
//     RUN tick              : minute+1; 59 -> 00 carries into hours; 23:59 -> 00:00.
//     The source operand is time_q for time states and alarm_q for alarm states.
//   Invalid BCD input: any field outside its legal range increments to 0.
//   Simultaneous events in one cycle:
//     - mode_btn wins over inc_btn; the inc pulse is dropped.
//     - mode_btn and minute_tick together: the state changes first; the tick follows
//       the rules of the new state.
//   Timeout (TIMEOUT_CYCLES > 0):
//     - The counter runs in SET states and resets on any button pulse or on state change.
//     - When count == TIMEOUT_CYCLES - 1, the state goes to RUN at the next edge.
//     - The counter is held at 0 in RUN.
// TESTING
//   1. Clear high for 2 cycles, then mode/inc/tick pulses -> all outputs 0, mode=0, no *_en.
//   2. RUN, time_q=13'h?(12:59), single tick -> one cycle later D_out=13:00, time_en=1 for 1 cycle.
//      Repeat with 23:59 -> 00:00.
//   3. Tick on two consecutive cycles -> two time_en pulses, separated by at least 1 idle
//      cycle; the second pulse uses the updated time_q; pending=0 at the end.
//   4. mode_btn x1, inc_btn x3 spaced 3 cycles apart, time 22:10 -> 23:10, 00:10, 01:10;
//      alarm_en never high.
//   5. mode_btn x4 to SET_A_MIN, alarm 07:59, inc -> alarm_en with 07:00; a tick in the same
//      window -> no time_en, pending=0.
//   6. TIMEOUT_CYCLES=8: enter SET_T_HR, stay idle -> mode=0 after exactly 8 cycles.
//      An inc at cycle 5 restarts the count.

Source files
------------

// File: rtl/time_register_controller.sv
// time_register_controller
//   Sequences writes into the alarm clock's current-time and alarm registers
//   over one shared D bus. RUN mode applies minute ticks to the current
//   time; the four SET modes let button pulses edit hours/minutes.
// Ports
//   Clock, Clear           : rising-edge clock, synchronous active-high reset
//   mode_btn, inc_btn      : 1-cycle debounced button pulses
//   minute_tick            : 1-cycle pulse once per minute
//   time_q, alarm_q        : register Q values (BCD hh:mm, 13 bits)
//   D_out                  : shared D bus, valid while an enable is high
//   time_en, alarm_en      : one-cycle register enables, never both high
//   mode                   : current state encoding
//   pending                : a minute tick is waiting to be applied
module time_register_controller #(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned TO_W           = 24
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        mode_btn,
    input  logic        inc_btn,
    input  logic        minute_tick,
    input  logic [12:0] time_q,
    input  logic [12:0] alarm_q,
    output logic [12:0] D_out,
    output logic        time_en,
    output logic        alarm_en,
    output logic [2:0]  mode,
    output logic        pending
);

    typedef enum logic [2:0] {
        RUN       = 3'd0,
        SET_T_HR  = 3'd1,
        SET_T_MIN = 3'd2,
        SET_A_HR  = 3'd3,
        SET_A_MIN = 3'd4
    } state_e;

    state_e          state_q, state_d, cur;
    logic [12:0]     d_out_q, d_out_d, src;
    logic            time_en_q, time_en_d, alarm_en_q, alarm_en_d;
    logic            pending_q, pending_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            in_flight, tick_wr, to_hit;
    logic [7:0]      mn;

    // Minute increment: returns {carry, tens, units}; invalid fields go to 0.
    function automatic logic [7:0] min_inc(input logic [6:0] m);
        logic [2:0] mt;
        logic [3:0] mu;
        logic       c;
        mt = m[6:4];
        mu = m[3:0];
        c  = 1'b0;
        if (mu >= 4'd9) begin
            mu = 4'd0;
            if (mt >= 3'd5) begin
                mt = 3'd0;
                c  = 1'b1;
            end else begin
                mt = mt + 3'd1;
            end
        end else begin
            mu = mu + 4'd1;
            if (mt > 3'd5) mt = 3'd0;
        end
        return {c, mt, mu};
    endfunction

    // Hour increment with 23 -> 00; any out-of-range hour also goes to 00.
    function automatic logic [5:0] hr_inc(input logic [5:0] h);
        logic [1:0] ht;
        logic [3:0] hu;
        ht = h[5:4];
        hu = h[3:0];
        if (ht > 2'd2 || hu > 4'd9 || (ht == 2'd2 && hu >= 4'd3)) return 6'd0;
        else if (hu == 4'd9) return {ht + 2'd1, 4'd0};
        else return {ht, hu + 4'd1};
    endfunction

    // Next-state, write sequencing, tick bookkeeping and timeout counter.
    always_comb begin
        cur        = (state_q > SET_A_MIN) ? RUN : state_q;
        state_d    = cur;
        d_out_d    = 13'd0;
        time_en_d  = 1'b0;
        alarm_en_d = 1'b0;
        pending_d  = 1'b0;
        to_cnt_d   = '0;
        tick_wr    = 1'b0;
        mn         = 8'd0;
        in_flight  = time_en_q | alarm_en_q;
        src        = (cur == SET_A_HR || cur == SET_A_MIN) ? alarm_q : time_q;
        to_hit     = (TIMEOUT_CYCLES != 0) && (cur != RUN)
                     && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

        if (mode_btn) begin
            case (cur)
                RUN:       state_d = SET_T_HR;
                SET_T_HR:  state_d = SET_T_MIN;
                SET_T_MIN: state_d = SET_A_HR;
                SET_A_HR:  state_d = SET_A_MIN;
                default:   state_d = RUN;
            endcase
        end else if (to_hit && !inc_btn) begin
            state_d = RUN;
        end

        if (state_d == RUN) begin
            // Ticks follow the rules of the state being entered.
            tick_wr = (cur == RUN) && pending_q && !in_flight;
            if (tick_wr) begin
                mn        = min_inc(time_q[6:0]);
                d_out_d   = {mn[7] ? hr_inc(time_q[12:7]) : time_q[12:7], mn[6:0]};
                time_en_d = 1'b1;
            end
            pending_d = (pending_q && !tick_wr) || minute_tick;
        end else if (inc_btn && !mode_btn && !in_flight) begin
            mn = min_inc(src[6:0]);
            if (cur == SET_T_HR || cur == SET_A_HR) d_out_d = {hr_inc(src[12:7]), src[6:0]};
            else                                    d_out_d = {src[12:7], mn[6:0]};
            time_en_d  = (cur == SET_T_HR || cur == SET_T_MIN);
            alarm_en_d = (cur == SET_A_HR || cur == SET_A_MIN);
        end

        // Counts idle cycles in a steady SET state only.
        if ((TIMEOUT_CYCLES != 0) && (state_d != RUN) && (state_d == cur)
            && !mode_btn && !inc_btn) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Clear) begin
            state_q    <= RUN;
            d_out_q    <= 13'd0;
            time_en_q  <= 1'b0;
            alarm_en_q <= 1'b0;
            pending_q  <= 1'b0;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            d_out_q    <= d_out_d;
            time_en_q  <= time_en_d;
            alarm_en_q <= alarm_en_d;
            pending_q  <= pending_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign D_out    = d_out_q;
    assign time_en  = time_en_q;
    assign alarm_en = alarm_en_q;
    assign mode     = state_q;
    assign pending  = pending_q;

endmodule

// File: tb/tb_time_register_controller.sv
// Directed bench for time_register_controller: one instance with the
// timeout disabled, a second with an 8-cycle timeout sharing the stimulus.
module tb_time_register_controller;

    logic        Clock, Clear, mode_btn, inc_btn, minute_tick;
    logic [12:0] time_r, alarm_r, ld_val;
    logic        ld_t, ld_a;
    logic [12:0] D_out, d2;
    logic        time_en, alarm_en, pending, ten2, aen2, pend2;
    logic [2:0]  mode, mode2;
    int          errors = 0;
    int          checks = 0;

    time_register_controller #(.TIMEOUT_CYCLES(0), .TO_W(24)) dut (
        .Clock(Clock), .Clear(Clear), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .minute_tick(minute_tick), .time_q(time_r), .alarm_q(alarm_r),
        .D_out(D_out), .time_en(time_en), .alarm_en(alarm_en),
        .mode(mode), .pending(pending));

    time_register_controller #(.TIMEOUT_CYCLES(8), .TO_W(24)) dut_to (
        .Clock(Clock), .Clear(Clear), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .minute_tick(minute_tick), .time_q(time_r), .alarm_q(alarm_r),
        .D_out(d2), .time_en(ten2), .alarm_en(aen2),
        .mode(mode2), .pending(pend2));

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Time and alarm registers driven by the first instance.
    always @(posedge Clock) begin
        if (time_en)   time_r <= D_out;
        else if (ld_t) time_r <= ld_val;
        if (alarm_en)  alarm_r <= D_out;
        else if (ld_a) alarm_r <= ld_val;
    end

    function automatic logic [12:0] bcd(input int ht, input int hu, input int mt, input int mu);
        return {2'(ht), 4'(hu), 3'(mt), 4'(mu)};
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk13(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_time(input logic [12:0] v);
        ld_val = v; ld_t = 1'b1; step(); ld_t = 1'b0;
    endtask

    task automatic load_alarm(input logic [12:0] v);
        ld_val = v; ld_a = 1'b1; step(); ld_a = 1'b0;
    endtask

    initial begin
        Clear = 1'b1; mode_btn = 1'b0; inc_btn = 1'b0; minute_tick = 1'b0;
        ld_t = 1'b0; ld_a = 1'b0; ld_val = 13'd0;

        // Clear held for two cycles, pulses during the second
        step();
        mode_btn = 1'b1; inc_btn = 1'b1; minute_tick = 1'b1;
        step();
        mode_btn = 1'b0; inc_btn = 1'b0; minute_tick = 1'b0;
        chk3 ("rst_mode",     mode,     3'd0);
        chk13("rst_dout",     D_out,    13'd0);
        chk1 ("rst_time_en",  time_en,  1'b0);
        chk1 ("rst_alarm_en", alarm_en, 1'b0);
        chk1 ("rst_pending",  pending,  1'b0);
        Clear = 1'b0;

        // RUN tick 12:59 -> 13:00
        load_time(bcd(1, 2, 5, 9));
        minute_tick = 1'b1; step(); minute_tick = 1'b0;
        chk1 ("t1259_pend", pending, 1'b1);
        chk1 ("t1259_en0",  time_en, 1'b0);
        step();
        chk1 ("t1259_en",   time_en, 1'b1);
        chk13("t1259_dout", D_out,   bcd(1, 3, 0, 0));
        chk1 ("t1259_pclr", pending, 1'b0);
        step();
        chk1 ("t1259_en1c", time_en, 1'b0);

        // RUN tick 23:59 -> 00:00
        load_time(bcd(2, 3, 5, 9));
        minute_tick = 1'b1; step(); minute_tick = 1'b0;
        step();
        chk1 ("t2359_en",   time_en, 1'b1);
        chk13("t2359_dout", D_out,   bcd(0, 0, 0, 0));
        step();

        // Back-to-back ticks from 10:05
        load_time(bcd(1, 0, 0, 5));
        minute_tick = 1'b1; step(); step(); minute_tick = 1'b0;
        chk1 ("bb_en1",   time_en, 1'b1);
        chk13("bb_dout1", D_out,   bcd(1, 0, 0, 6));
        chk1 ("bb_pend1", pending, 1'b1);
        step();
        chk1 ("bb_gap",   time_en, 1'b0);
        chk1 ("bb_pendg", pending, 1'b1);
        step();
        chk1 ("bb_en2",   time_en, 1'b1);
        chk13("bb_dout2", D_out,   bcd(1, 0, 0, 7));
        chk1 ("bb_pend2", pending, 1'b0);
        step();
        chk1 ("bb_end",   pending, 1'b0);

        // SET_T_HR: 22:10 -> 23:10 -> 00:10 -> 01:10
        load_time(bcd(2, 2, 1, 0));
        mode_btn = 1'b1; step(); mode_btn = 1'b0;
        chk3 ("hr_mode", mode, 3'd1);
        inc_btn = 1'b1; step(); inc_btn = 1'b0;
        chk1 ("hr1_en",  time_en,  1'b1);
        chk1 ("hr1_aen", alarm_en, 1'b0);
        chk13("hr1_d",   D_out,    bcd(2, 3, 1, 0));
        step(); step();
        inc_btn = 1'b1; step(); inc_btn = 1'b0;
        chk1 ("hr2_en",  time_en,  1'b1);
        chk1 ("hr2_aen", alarm_en, 1'b0);
        chk13("hr2_d",   D_out,    bcd(0, 0, 1, 0));
        step(); step();
        inc_btn = 1'b1; step();
        chk1 ("hr3_en",  time_en,  1'b1);
        chk13("hr3_d",   D_out,    bcd(0, 1, 1, 0));
        step(); inc_btn = 1'b0;
        chk1 ("hr_drop", time_en,  1'b0);
        chk1 ("hr_drop_aen", alarm_en, 1'b0);
        minute_tick = 1'b1; step(); minute_tick = 1'b0;
        chk1 ("set_tick_pend", pending, 1'b0);
        chk1 ("set_tick_en",   time_en, 1'b0);

        // SET_A_MIN: 07:59 -> 07:00, with a tick in the same cycle
        mode_btn = 1'b1; step(); step(); step(); mode_btn = 1'b0;
        chk3 ("amin_mode", mode, 3'd4);
        load_alarm(bcd(0, 7, 5, 9));
        inc_btn = 1'b1; minute_tick = 1'b1; step(); inc_btn = 1'b0; minute_tick = 1'b0;
        chk1 ("amin_aen",  alarm_en, 1'b1);
        chk1 ("amin_ten",  time_en,  1'b0);
        chk13("amin_d",    D_out,    bcd(0, 7, 0, 0));
        chk1 ("amin_pend", pending,  1'b0);
        step();
        chk1 ("amin_aen1c", alarm_en, 1'b0);

        // mode_btn with tick into RUN: tick is kept and applied to 01:10
        mode_btn = 1'b1; minute_tick = 1'b1; step(); mode_btn = 1'b0; minute_tick = 1'b0;
        chk3 ("mt_mode", mode,    3'd0);
        chk1 ("mt_pend", pending, 1'b1);
        step();
        chk1 ("mt_en",   time_en, 1'b1);
        chk13("mt_d",    D_out,   bcd(0, 1, 1, 1));
        step();

        // mode_btn beats inc_btn
        mode_btn = 1'b1; inc_btn = 1'b1; step(); mode_btn = 1'b0; inc_btn = 1'b0;
        chk3 ("mi_mode", mode,    3'd1);
        chk1 ("mi_en",   time_en, 1'b0);

        // Timeout of 8 cycles, restarted by an inc at cycle 5
        Clear = 1'b1; step(); Clear = 1'b0;
        chk3 ("to_rst", mode2, 3'd0);
        mode_btn = 1'b1; step(); mode_btn = 1'b0;
        chk3 ("to_enter", mode2, 3'd1);
        for (int i = 0; i < 4; i++) step();
        inc_btn = 1'b1; step(); inc_btn = 1'b0;
        chk1 ("to_inc_en", ten2,    1'b1);
        chk13("to_inc_d",  d2,      bcd(0, 2, 1, 1));
        chk13("to_inc_d1", D_out,   bcd(0, 2, 1, 1));
        for (int i = 0; i < 7; i++) step();
        chk3 ("to_restart_hold", mode2, 3'd1);
        step();
        chk3 ("to_restart_fire", mode2, 3'd0);
        mode_btn = 1'b1; step(); mode_btn = 1'b0;
        chk3 ("to_enter2", mode2, 3'd1);
        chk3 ("to_nodis",  mode,  3'd2);
        for (int i = 0; i < 7; i++) step();
        chk3 ("to_hold7", mode2, 3'd1);
        step();
        chk3 ("to_fire8", mode2, 3'd0);
        chk3 ("to_disabled", mode, 3'd2);
        chk1 ("to_aen", aen2,  1'b0);
        chk1 ("to_pend", pend2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
